div_seq_core: RTL and testbench

Sequential radix-2 restoring divider for the CPU execute stage. Sits directly under the divide execution unit: it takes a one-cycle request with a 32-bit dividend and 16-bit divisor, and iterates one quotient bit per cycle. It returns quotient and remainder with a one-cycle acknowledge. It detects divide-by-zero and quotient overflow (the x86 type-0 fault conditions) and flags them on the same acknowledge.

---
 rtl/div_seq_core.sv | 202 ++++++++++++++++++++
 tb/tb_div_seq_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_core.sv
// Sequential radix-2 restoring divider: 32/16 (word) or 16/8 (byte), signed or unsigned,
// one quotient bit per cycle, with divide-by-zero and quotient-overflow fault detection.
module div_seq_core (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iStall,
   input  logic        iReq,
   input  logic        iSgn,
   input  logic        iBW,
   input  logic [31:0] iNumer,
   input  logic [15:0] iDenom,
   output logic [15:0] oQuotient,
   output logic [15:0] oRemain,
   output logic        oAck,
   output logic        oErr
);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t      stateReg, stateNext;

   logic [31:0] numerReg, numerNext;
   logic [15:0] denomReg, denomNext;
   logic        sgnReg, sgnNext;
   logic        bwReg, bwNext;
   logic        qnegReg, qnegNext;
   logic        rnegReg, rnegNext;
   logic [15:0] absDReg, absDNext;
   logic [15:0] remReg, remNext;
   logic [15:0] qReg, qNext;
   logic [4:0]  cntReg, cntNext;
   logic [15:0] quotReg, quotNext;
   logic [15:0] remOutReg, remOutNext;
   logic        ackReg, ackNext;
   logic        errReg, errNext;

   logic        numNeg, denNeg, preErr;
   logic [31:0] absN;
   logic [15:0] absD, upperHalf, lowerHalf;
   logic [16:0] trial;
   logic [15:0] qSigned, rSigned, qOut, rOut, qLimit;
   logic        ovf;

   // Operand magnitudes and pre-check; byte mode left-aligns the low byte in the
   // shift register so both widths shift out of bit 15.
   always_comb begin
      numNeg    = 1'b0;
      denNeg    = 1'b0;
      absN      = '0;
      absD      = '0;
      upperHalf = '0;
      lowerHalf = '0;
      if (bwReg) begin
         numNeg    = sgnReg & numerReg[31];
         denNeg    = sgnReg & denomReg[15];
         absN      = numNeg ? (~numerReg + 32'd1) : numerReg;
         absD      = denNeg ? (~denomReg + 16'd1) : denomReg;
         upperHalf = absN[31:16];
         lowerHalf = absN[15:0];
      end else begin
         numNeg    = sgnReg & numerReg[15];
         denNeg    = sgnReg & denomReg[7];
         absN      = {16'h0000, numNeg ? (~numerReg[15:0] + 16'd1) : numerReg[15:0]};
         absD      = {8'h00, denNeg ? (~denomReg[7:0] + 8'd1) : denomReg[7:0]};
         upperHalf = {8'h00, absN[15:8]};
         lowerHalf = {absN[7:0], 8'h00};
      end
      preErr = (absD == 16'h0000) || (upperHalf >= absD);
   end

   always_comb begin
      trial   = {remReg, qReg[15]} - {1'b0, absDReg};
      qSigned = qnegReg ? (~qReg + 16'd1) : qReg;
      rSigned = rnegReg ? (~remReg + 16'd1) : remReg;
      qOut    = bwReg ? qSigned : {8'h00, qSigned[7:0]};
      rOut    = bwReg ? rSigned : {8'h00, rSigned[7:0]};
      // A negative result may reach one past the positive limit (-128 / -32768).
      if (bwReg) qLimit = qnegReg ? 16'd32768 : 16'd32767;
      else       qLimit = qnegReg ? 16'd128   : 16'd127;
      ovf = sgnReg && (qReg > qLimit);
   end

   always_ff @(posedge iClk) begin
      if (iRst)         stateReg <= IDLE;
      else if (!iStall) stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (iReq) stateNext = PREP;
         PREP:    stateNext = preErr ? DONE : ITER;
         ITER:    if (cntReg == 5'd1) stateNext = FIX;
         FIX:     stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      numerNext  = numerReg;
      denomNext  = denomReg;
      sgnNext    = sgnReg;
      bwNext     = bwReg;
      qnegNext   = qnegReg;
      rnegNext   = rnegReg;
      absDNext   = absDReg;
      remNext    = remReg;
      qNext      = qReg;
      cntNext    = cntReg;
      quotNext   = quotReg;
      remOutNext = remOutReg;
      ackNext    = ackReg;
      errNext    = errReg;
      case (stateReg)
         IDLE: begin
            if (iReq) begin
               numerNext = iNumer;
               denomNext = iDenom;
               sgnNext   = iSgn;
               bwNext    = iBW;
            end
         end
         PREP: begin
            qnegNext = numNeg ^ denNeg;
            rnegNext = numNeg;
            absDNext = absD;
            if (preErr) begin
               quotNext   = 16'h0000;
               remOutNext = 16'h0000;
               ackNext    = 1'b1;
               errNext    = 1'b1;
            end else begin
               remNext = upperHalf;
               qNext   = lowerHalf;
               cntNext = bwReg ? 5'd16 : 5'd8;
            end
         end
         ITER: begin
            if (!trial[16]) begin
               remNext = trial[15:0];
               qNext   = {qReg[14:0], 1'b1};
            end else begin
               remNext = {remReg[14:0], qReg[15]};
               qNext   = {qReg[14:0], 1'b0};
            end
            cntNext = cntReg - 5'd1;
         end
         FIX: begin
            ackNext    = 1'b1;
            errNext    = ovf;
            quotNext   = ovf ? 16'h0000 : qOut;
            remOutNext = ovf ? 16'h0000 : rOut;
         end
         DONE: begin
            ackNext = 1'b0;
            errNext = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         numerReg  <= '0;
         denomReg  <= '0;
         sgnReg    <= 1'b0;
         bwReg     <= 1'b0;
         qnegReg   <= 1'b0;
         rnegReg   <= 1'b0;
         absDReg   <= '0;
         remReg    <= '0;
         qReg      <= '0;
         cntReg    <= '0;
         quotReg   <= '0;
         remOutReg <= '0;
         ackReg    <= 1'b0;
         errReg    <= 1'b0;
      end else if (!iStall) begin
         numerReg  <= numerNext;
         denomReg  <= denomNext;
         sgnReg    <= sgnNext;
         bwReg     <= bwNext;
         qnegReg   <= qnegNext;
         rnegReg   <= rnegNext;
         absDReg   <= absDNext;
         remReg    <= remNext;
         qReg      <= qNext;
         cntReg    <= cntNext;
         quotReg   <= quotNext;
         remOutReg <= remOutNext;
         ackReg    <= ackNext;
         errReg    <= errNext;
      end
   end

   assign oQuotient = quotReg;
   assign oRemain   = remOutReg;
   assign oAck      = ackReg;
   assign oErr      = errReg;

endmodule

// File: tb/tb_div_seq_core.sv
// Self-checking bench for div_seq_core: directed vector table, hand-written multi-cycle
// sequences (busy, stall in IDLE, reset abort) and randomized ops against an arithmetic model.
module tb_div_seq_core;

   logic        iClk = 1'b0;
   logic        iRst, iStall, iReq, iSgn, iBW;
   logic [31:0] iNumer;
   logic [15:0] iDenom;
   logic [15:0] oQuotient, oRemain;
   logic        oAck, oErr;

   int errors = 0;
   int checks = 0;

   div_seq_core dut (
      .iClk(iClk), .iRst(iRst), .iStall(iStall), .iReq(iReq), .iSgn(iSgn), .iBW(iBW),
      .iNumer(iNumer), .iDenom(iDenom),
      .oQuotient(oQuotient), .oRemain(oRemain), .oAck(oAck), .oErr(oErr)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic        sgn;
      logic        bw;
      logic [31:0] numer;
      logic [15:0] denom;
      int          stS;
      int          stL;
      logic [15:0] q;
      logic [15:0] r;
      logic        err;
      int          lat;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Plain integer arithmetic: truncating division, remainder with dividend sign.
   function automatic void refModel(input logic sgn, input logic bw, input logic [31:0] numer,
                                    input logic [15:0] denom, output logic [15:0] q,
                                    output logic [15:0] r, output logic err, output int lat);
      longint n, d, mq, qq, rr, hi, lo;
      if (bw) begin
         if (sgn) begin n = $signed(numer); d = $signed(denom); end
         else     begin n = numer;          d = denom;          end
      end else begin
         if (sgn) begin n = $signed(numer[15:0]); d = $signed(denom[7:0]); end
         else     begin n = numer[15:0];          d = denom[7:0];          end
      end
      q = 16'h0000; r = 16'h0000; err = 1'b0;
      lat = bw ? 19 : 11;
      if (d == 0) begin err = 1'b1; lat = 2; return; end
      mq = (n < 0 ? -n : n) / (d < 0 ? -d : d);
      if (mq >= (bw ? 65536 : 256)) begin err = 1'b1; lat = 2; return; end
      qq = n / d;
      rr = n % d;
      if (sgn) begin
         hi = bw ? 32767 : 127;
         lo = -(hi + 1);
         if (qq > hi || qq < lo) begin err = 1'b1; return; end
      end
      q = bw ? qq[15:0] : {8'h00, qq[7:0]};
      r = bw ? rr[15:0] : {8'h00, rr[7:0]};
   endfunction

   // Called at a negedge; returns at the negedge of the cycle after oAck.
   task automatic runOp(input logic sgn, input logic bw, input logic [31:0] numer,
                        input logic [15:0] denom, input int stS, input int stL, input string tag,
                        output int lat, output logic [15:0] q, output logic [15:0] r,
                        output logic err);
      int cyc;
      iSgn = sgn; iBW = bw; iNumer = numer; iDenom = denom; iReq = 1'b1; iStall = 1'b0;
      @(posedge iClk); cyc = 1;
      @(negedge iClk);
      iReq = 1'b0; iNumer = $urandom; iDenom = 16'($urandom);
      iSgn = 1'($urandom); iBW = 1'($urandom);
      while (!oAck && cyc < 100) begin
         iStall = (cyc + 1 >= stS) && (cyc + 1 < stS + stL);
         @(posedge iClk); cyc++;
         @(negedge iClk);
      end
      iStall = 1'b0;
      lat = cyc; q = oQuotient; r = oRemain; err = oErr;
      if (!oAck) begin
         checks++; errors++;
         $display("FAIL %s_timeout: no oAck within %0d cycles", tag, cyc);
      end
      $display("%s sgn=%0d bw=%0d N=%h D=%h -> q=%h r=%h err=%0d lat=%0d",
               tag, sgn, bw, numer, denom, q, r, err, lat);
      @(posedge iClk);
      @(negedge iClk);
      check({tag, "_ackpulse"}, {31'd0, oAck}, 32'd0);
      check({tag, "_errIdle"}, {31'd0, oErr}, 32'd0);
   endtask

   initial begin
      int lat, cyc, ackCnt, firstAck, eLat;
      logic [15:0] q, r, eq, er, q2, r2;
      logic err, eErr, sgn, bw;
      logic [31:0] numer;
      logic [15:0] denom;
      int stS, stL, mode;

      vecs[0]  = '{1'b0, 1'b1, 32'h0001_0000, 16'h0003, 0, 0, 16'h5555, 16'h0001, 1'b0, 19};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_FF9C, 16'h0007, 0, 0, 16'h00F2, 16'h00FE, 1'b0, 11};
      vecs[2]  = '{1'b0, 1'b1, 32'h1234_5678, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1'b1, 2};
      vecs[3]  = '{1'b0, 1'b1, 32'h0003_0000, 16'h0003, 0, 0, 16'h0000, 16'h0000, 1'b1, 2};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000_FF80, 16'h0001, 0, 0, 16'h0080, 16'h0000, 1'b0, 11};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0080, 16'h0001, 0, 0, 16'h0000, 16'h0000, 1'b1, 11};
      vecs[6]  = '{1'b1, 1'b1, 32'h0000_8000, 16'h0001, 0, 0, 16'h0000, 16'h0000, 1'b1, 19};
      vecs[7]  = '{1'b1, 1'b1, 32'hFFFF_8000, 16'h0001, 0, 0, 16'h8000, 16'h0000, 1'b0, 19};
      vecs[8]  = '{1'b0, 1'b1, 32'h0001_0000, 16'h0003, 4, 5, 16'h5555, 16'h0001, 1'b0, 24};
      vecs[9]  = '{1'b0, 1'b0, 32'hABCD_00FF, 16'hFF10, 0, 0, 16'h000F, 16'h000F, 1'b0, 11};
      vecs[10] = '{1'b1, 1'b1, 32'hFFF0_BDC0, 16'h03E8, 0, 0, 16'hFC18, 16'h0000, 1'b0, 19};
      vecs[11] = '{1'b1, 1'b1, 32'h0000_0007, 16'hFFFE, 0, 0, 16'hFFFD, 16'h0001, 1'b0, 19};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_0010, 16'h0100, 0, 0, 16'h0000, 16'h0000, 1'b1, 2};

      iRst = 1'b1; iStall = 1'b0; iReq = 1'b0; iSgn = 1'b0; iBW = 1'b0;
      iNumer = '0; iDenom = '0;
      repeat (3) @(posedge iClk);
      @(negedge iClk);
      iRst = 1'b0;
      check("reset_ack", {31'd0, oAck}, 32'd0);
      check("reset_err", {31'd0, oErr}, 32'd0);
      check("reset_q", {16'd0, oQuotient}, 32'd0);
      check("reset_r", {16'd0, oRemain}, 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         runOp(vecs[i].sgn, vecs[i].bw, vecs[i].numer, vecs[i].denom, vecs[i].stS, vecs[i].stL,
               $sformatf("vec%0d", i), lat, q, r, err);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_q", i), {16'd0, q}, {16'd0, vecs[i].q});
         check($sformatf("vec%0d_r", i), {16'd0, r}, {16'd0, vecs[i].r});
         check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      end

      // Second request while busy must be dropped.
      iSgn = 1'b0; iBW = 1'b1; iNumer = 32'h0001_0000; iDenom = 16'h0003; iReq = 1'b1;
      @(posedge iClk); cyc = 1;
      @(negedge iClk); iReq = 1'b0;
      while (!oAck && cyc < 100) begin
         if (cyc == 4) begin iReq = 1'b1; iNumer = 32'h0002_0000; iDenom = 16'h0007; end
         else iReq = 1'b0;
         @(posedge iClk); cyc++;
         @(negedge iClk);
      end
      iReq = 1'b0;
      $display("busy N=00010000 D=0003 -> q=%h r=%h err=%0d lat=%0d", oQuotient, oRemain, oErr, cyc);
      check("busy_lat", cyc, 19);
      check("busy_q", {16'd0, oQuotient}, 32'h5555);
      check("busy_r", {16'd0, oRemain}, 32'h0001);
      ackCnt = 0;
      repeat (30) begin
         @(posedge iClk); @(negedge iClk);
         if (oAck) ackCnt++;
      end
      check("busy_noSecondAck", ackCnt, 0);

      // Request held with iStall=1 in IDLE is only accepted once the stall drops.
      iSgn = 1'b1; iBW = 1'b0; iNumer = 32'h0000_0064; iDenom = 16'h00F9; iReq = 1'b1; iStall = 1'b1;
      repeat (3) begin @(posedge iClk); @(negedge iClk); end
      iStall = 1'b0;
      @(posedge iClk); cyc = 1;
      @(negedge iClk); iReq = 1'b0;
      while (!oAck && cyc < 100) begin
         @(posedge iClk); cyc++;
         @(negedge iClk);
      end
      $display("idleStall N=0064 D=F9 -> q=%h r=%h err=%0d lat=%0d", oQuotient, oRemain, oErr, cyc);
      check("idleStall_lat", cyc, 11);
      check("idleStall_q", {16'd0, oQuotient}, 32'h00F2);
      check("idleStall_r", {16'd0, oRemain}, 32'h0002);
      @(posedge iClk); @(negedge iClk);

      // Reset in the middle of a word divide, then a fresh request at T+10.
      iSgn = 1'b0; iBW = 1'b1; iNumer = 32'h0001_0000; iDenom = 16'h0003; iReq = 1'b1;
      ackCnt = 0; firstAck = 0; q2 = '0; r2 = '0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge iClk); @(negedge iClk);
         if (k == 1) iReq = 1'b0;
         if (oAck) begin
            ackCnt++;
            if (firstAck == 0) begin firstAck = k; q2 = oQuotient; r2 = oRemain; end
         end
         if (k == 8) iRst = 1'b1;
         if (k == 9) begin
            iRst = 1'b0;
            check("rst_q", {16'd0, oQuotient}, 32'd0);
            check("rst_r", {16'd0, oRemain}, 32'd0);
            check("rst_ack", {31'd0, oAck}, 32'd0);
         end
         if (k == 10) begin iNumer = 32'h0001_0000; iDenom = 16'h0007; iReq = 1'b1; end
         if (k == 11) iReq = 1'b0;
      end
      $display("reset abort then N=00010000 D=0007 -> q=%h r=%h acks=%0d at=%0d", q2, r2, ackCnt, firstAck);
      check("rst_ackCount", ackCnt, 1);
      check("rst_ackCycle", firstAck, 29);
      check("rst_q2", {16'd0, q2}, 32'h2492);
      check("rst_r2", {16'd0, r2}, 32'h0002);

      for (int i = 0; i < 150; i++) begin
         sgn = 1'($urandom); bw = 1'($urandom);
         numer = $urandom; denom = 16'($urandom);
         mode = $urandom_range(0, 4);
         if (mode == 1) numer = {{16{numer[15]}}, numer[15:0]};
         if (mode == 2) numer = {16'h0000, {8{numer[7]}}, numer[7:0]};
         if (mode == 3) denom = {8'h00, denom[7:0]} & 16'hFF00;
         stS = $urandom_range(2, 12);
         stL = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         refModel(sgn, bw, numer, denom, eq, er, eErr, eLat);
         if (stL > 0 && stS <= eLat) eLat = eLat + stL;
         runOp(sgn, bw, numer, denom, stS, stL, $sformatf("rnd%0d", i), lat, q, r, err);
         check($sformatf("rnd%0d_lat", i), lat, eLat);
         check($sformatf("rnd%0d_q", i), {16'd0, q}, {16'd0, eq});
         check($sformatf("rnd%0d_r", i), {16'd0, r}, {16'd0, er});
         check($sformatf("rnd%0d_err", i), {31'd0, err}, {31'd0, eErr});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
